tdm_demux8: RTL
===============

# tdm_demux8

Registered 1-to-8 demultiplexer: the receiving end of an 8-way time-division link whose transmit side is an 8:1 mux (74AC151-class) stepped by a 3-bit slot counter. Runs in two modes: scan mode collects a framed sample stream into a shadow bank and commits all eight slots at once, and addressed mode writes one slot directly, like a 74HC259 addressable latch. It sits in the glue logic that restores parallel signals after a mux-based serial path, and its `slot` output can drive the remote mux select.

## Interface
- `W`, 1: width of each slot sample.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mode`  in  1: 0 = addressed, 1 = scan.
- `d`  in  W: sample data (both modes).
- `addr`  in  3: target slot, addressed mode only.
- `we`  in  1: write strobe, addressed mode only.
- `clr`  in  1: synchronous clear of `q` and the shadow bank, both modes.
- `sync`  in  1: frame start, scan mode; qualified by `valid`.
- `valid`  in  1: sample strobe, scan mode.
- `q`  out  8*W: output bank; slot n occupies bits [n*W +: W].
- `slot`  out  3: current scan slot counter.
- `frame_done`  out  1: one-cycle pulse when a frame commits to `q`.
- `sync_err`  out  1: sticky flag; a frame was aborted by an early `sync`.

## Operation
- Reset: `q`=0, shadow=0, `slot`=0, `frame_done`=0, `sync_err`=0, state IDLE.
- Addressed mode (`mode`=0):
  - `we` writes `d` into q[addr] at the next edge; other slots hold.
  - The scan FSM is forced to IDLE with `slot`=0.
- Scan FSM, two states, scan mode only:
  - IDLE, `valid`&`sync`: shadow[0]←`d`, `slot`←1, go to RUN.
  - IDLE, `valid` without `sync`: ignored.
  - RUN, `valid`&!`sync`: shadow[slot]←`d`, `slot`←`slot`+1.
  - RUN, `valid`&!`sync` when `slot`=7: `q` gets the shadow bank with slot 7 taken from `d`, `frame_done`=1, `slot`←0, go to IDLE.
  - RUN, `valid`&`sync` when `slot`≠0: `sync_err`←1 and the partial frame is discarded. That sample restarts a frame: shadow[0]←`d`, `slot`←1, stay in RUN.
  - `valid`=0: no change; gaps inside a frame are allowed.
- `q` changes only on a frame commit, never slot by slot.
- `clr` takes priority over `we` and over a commit in the same cycle:
  - `q` and shadow are cleared, any open frame is aborted (state IDLE, `slot`=0), `frame_done` stays 0.
  - `sync_err` is unaffected; only `rst` clears it.
- A `mode` change aborts any open frame silently: IDLE, `slot`=0, no `sync_err`. `q` is kept.
- `rst` in the middle of a frame returns every register to its reset value; no partial commit.

## Timing
- Addressed write: `q` is updated at the edge that samples `we`, one cycle of latency.
- Scan commit: `q` and `frame_done` update together at the edge that samples slot 7. `frame_done` is high for exactly that following cycle.
- `slot` is registered and valid from the cycle after each accepted sample, so the transmitter can read it as the next select.
- Minimum frame is 8 consecutive `valid` cycles. Back-to-back frames are supported: a `sync` on the cycle right after a commit starts the next frame, and `frame_done` is not lost.
- No combinational path from any input to any output.

## Structure
- Package `demux74_pkg`:
  - `SLOTS`=8, `SEL_W`=3.
  - State enum {IDLE, RUN}.
  - Slot-slice helper function.
- Sub-module `dec3to8`: 3-to-8 one-hot decoder with enable, the 74AC138 equivalent. One instance decodes `addr` and one decodes `slot`; each result gates the per-slot write enables.
- Top level holds the FSM, counter, shadow bank, output bank and error flag.

## Test plan
- Reset, then 8 scan samples `d`=1,0,1,1,0,0,1,0 (W=1, `sync` on the first): `q`=8'b01001101 and a single `frame_done` on the cycle after the 8th; `slot` runs 1..7 then 0.
- Addressed mode, `we` with `addr`=5 and `d`=1, then `addr`=2 and `d`=1: `q`=8'h24 one cycle after each write, other bits unchanged.
- Scan: `sync` frame, 4 samples, then a new `sync` with `d`=1 and 7 more samples of 0: `sync_err`=1, `q`=8'h01, no commit for the aborted frame.
- `clr` in the same cycle as the slot-7 sample: `q`=0, no `frame_done`, `slot`=0; the next `sync` frame commits normally.
- Two frames back-to-back with `valid` held high for 16 cycles: two `frame_done` pulses 8 cycles apart, `q` equals the second frame.
- `rst` asserted after 3 samples: all outputs 0 next cycle; a following full frame commits correctly.

Source files
------------

// File: rtl/demux74_pkg.sv
// Shared constants, scan FSM state type and slot-slicing helper for the TDM demux.
package demux74_pkg;

  localparam int unsigned SLOTS = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } scan_state_e;

  // LSB position of slot n in a flat bank of w-bit slots.
  function automatic int unsigned slot_lsb(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low while disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Registered 1-to-8 TDM demultiplexer: framed scan collection into a shadow bank with
// atomic commit, plus an addressed single-slot write mode.
module tdm_demux8
  import demux74_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
  input  logic [W-1:0]       d_i,
  input  logic [SEL_W-1:0]   addr_i,
  input  logic               we_i,
  input  logic               clr_i,
  input  logic               sync_i,
  input  logic               valid_i,
  output logic [SLOTS*W-1:0] q_o,
  output logic [SEL_W-1:0]   slot_o,
  output logic               frame_done_o,
  output logic               sync_err_o
);

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(SLOTS - 1);

  scan_state_e state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [SLOTS-1:0][W-1:0] shadow_q, shadow_d;
  logic [SLOTS-1:0][W-1:0] q_q, q_d;
  logic frame_done_q, frame_done_d;
  logic sync_err_q, sync_err_d;

  logic [SLOTS-1:0] addr_wen;
  logic [SLOTS-1:0] scan_wen;
  logic [SEL_W-1:0] scan_sel;
  logic             scan_acc;

  // A sync sample always lands in slot 0; otherwise the running counter selects.
  assign scan_sel = sync_i ? '0 : slot_q;
  assign scan_acc = mode_i & valid_i & (sync_i | (state_q == StRun));

  dec3to8 u_dec_addr (
    .en_i  (~mode_i & we_i),
    .sel_i (addr_i),
    .y_o   (addr_wen)
  );

  dec3to8 u_dec_slot (
    .en_i  (scan_acc),
    .sel_i (scan_sel),
    .y_o   (scan_wen)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    q_d          = q_q;
    frame_done_d = 1'b0;
    sync_err_d   = sync_err_q;

    if (clr_i) begin
      q_d      = '0;
      shadow_d = '0;
      state_d  = StIdle;
      slot_d   = '0;
    end else if (!mode_i) begin
      state_d = StIdle;
      slot_d  = '0;
      for (int unsigned n = 0; n < SLOTS; n++) begin
        if (addr_wen[n]) q_d[n] = d_i;
      end
    end else if (valid_i) begin
      for (int unsigned n = 0; n < SLOTS; n++) begin
        if (scan_wen[n]) shadow_d[n] = d_i;
      end
      if (sync_i) begin
        // An early sync abandons the open frame and restarts from this sample.
        if (state_q == StRun) sync_err_d = 1'b1;
        state_d = StRun;
        slot_d  = SEL_W'(1);
      end else if (state_q == StRun) begin
        if (slot_q == LastSlot) begin
          for (int unsigned n = 0; n < SLOTS; n++) begin
            q_d[n] = (n == SLOTS - 1) ? d_i : shadow_q[n];
          end
          frame_done_d = 1'b1;
          state_d      = StIdle;
          slot_d       = '0;
        end else begin
          slot_d = slot_q + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      slot_q       <= '0;
      shadow_q     <= '0;
      q_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      q_q          <= q_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  for (genvar n = 0; n < SLOTS; n++) begin : g_q_out
    assign q_o[slot_lsb(n, W) +: W] = q_q[n];
  end

  assign slot_o       = slot_q;
  assign frame_done_o = frame_done_q;
  assign sync_err_o   = sync_err_q;

endmodule
